// File: rtl/timer_intr.sv
// timer_intr -- memory-mapped 64-bit machine timer with a compare interrupt.
//
// A prescaler divides the clock into ticks, and each tick advances mtime.
// t_intr is a registered level that is high while the timer is enabled and
// mtime >= mtimecmp.
//
// Optional feature macro: TIMER_PERIODIC_EN
//   Defined     : CTRL[1] (periodic) and the PERIOD register exist. On every
//                 match, mtimecmp advances by PERIOD, so t_intr pulses.
//   Not defined : CTRL[1] and PERIOD read 0 and ignore writes.
//
// Ports
//   clk_i    in   clock; all state updates on the rising edge
//   rst_i    in   synchronous reset, active-low
//   cs       in   chip select
//   we       in   write enable (a write needs cs=1 and we=1)
//   mask     in   [3:0] byte-lane write enables for wdata_i
//   addr_i   in   [2:0] register index:
//                   0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI,
//                   4 CTRL, 5 PRESCALE, 6 PERIOD, 7 reserved
//   wdata_i  in   [DW-1:0] write data
//   rdata_o  out  [DW-1:0] combinational read data (0 when cs=0 or in reset)
//   t_intr   out  timer interrupt level
module timer_intr #(
    parameter int DW      = 32,
    parameter int PRESC_W = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cs,
    input  logic          we,
    input  logic [3:0]    mask,
    input  logic [2:0]    addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          t_intr
);
    localparam logic [2:0] A_MTIME_LO = 3'd0;
    localparam logic [2:0] A_MTIME_HI = 3'd1;
    localparam logic [2:0] A_CMP_LO   = 3'd2;
    localparam logic [2:0] A_CMP_HI   = 3'd3;
    localparam logic [2:0] A_CTRL     = 3'd4;
    localparam logic [2:0] A_PRESCALE = 3'd5;
    localparam logic [2:0] A_PERIOD   = 3'd6;

    logic [63:0]        mtime_q, mtime_d;
    logic [63:0]        mtimecmp_q, mtimecmp_d;
    logic               enable_q, enable_d;
    logic [PRESC_W-1:0] prescale_q, prescale_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic               t_intr_q, t_intr_d;
`ifdef TIMER_PERIODIC_EN
    logic               periodic_q, periodic_d;
    logic [DW-1:0]      period_q, period_d;
`endif

    logic          wr;
    logic [DW-1:0] bm;
    logic          tick;
    logic          match;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] wd,
                                            input logic [DW-1:0] bmask);
        return (old & ~bmask) | (wd & bmask);
    endfunction

    always_comb begin
        wr    = cs && we;
        bm    = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        tick  = enable_q && (presc_cnt_q == prescale_q);
        match = (mtime_q >= mtimecmp_q);

        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        enable_d    = enable_q;
        prescale_d  = prescale_q;
        presc_cnt_d = presc_cnt_q;
        t_intr_d    = enable_q && match;
`ifdef TIMER_PERIODIC_EN
        periodic_d  = periodic_q;
        period_d    = period_q;
`endif

        // A software write to either mtime half replaces the tick increment
        // entirely: the other half holds and no carry propagates.
        if (wr && addr_i == A_MTIME_LO) begin
            mtime_d[31:0] = merge(mtime_q[31:0], wdata_i, bm);
        end else if (wr && addr_i == A_MTIME_HI) begin
            mtime_d[63:32] = merge(mtime_q[63:32], wdata_i, bm);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        // Software writes to mtimecmp win over the periodic reload.
        if (wr && addr_i == A_CMP_LO) begin
            mtimecmp_d[31:0] = merge(mtimecmp_q[31:0], wdata_i, bm);
        end else if (wr && addr_i == A_CMP_HI) begin
            mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wdata_i, bm);
        end
`ifdef TIMER_PERIODIC_EN
        else if (enable_q && periodic_q && match) begin
            mtimecmp_d = mtimecmp_q + {32'b0, period_q};
        end
`endif

        // Only the low CTRL byte holds state, so only mask[0] matters.
        if (wr && addr_i == A_CTRL) begin
            enable_d = (enable_q & ~bm[0]) | (wdata_i[0] & bm[0]);
`ifdef TIMER_PERIODIC_EN
            periodic_d = (periodic_q & ~bm[1]) | (wdata_i[1] & bm[1]);
`endif
        end

        if (wr && addr_i == A_PRESCALE) begin
            prescale_d = (prescale_q & ~bm[PRESC_W-1:0])
                       | (wdata_i[PRESC_W-1:0] & bm[PRESC_W-1:0]);
        end

`ifdef TIMER_PERIODIC_EN
        if (wr && addr_i == A_PERIOD) begin
            period_d = merge(period_q, wdata_i, bm);
        end
`endif

        // Restart the prescale phase whenever its divisor or the enable changes.
        if (!enable_q || (wr && (addr_i == A_CTRL || addr_i == A_PRESCALE))) begin
            presc_cnt_d = '0;
        end else if (tick) begin
            presc_cnt_d = '0;
        end else begin
            presc_cnt_d = presc_cnt_q + {{(PRESC_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        rdata_o = '0;
        if (rst_i && cs) begin
            case (addr_i)
                A_MTIME_LO: rdata_o = mtime_q[31:0];
                A_MTIME_HI: rdata_o = mtime_q[63:32];
                A_CMP_LO:   rdata_o = mtimecmp_q[31:0];
                A_CMP_HI:   rdata_o = mtimecmp_q[63:32];
`ifdef TIMER_PERIODIC_EN
                A_CTRL:     rdata_o = {30'b0, periodic_q, enable_q};
                A_PERIOD:   rdata_o = period_q;
`else
                A_CTRL:     rdata_o = {31'b0, enable_q};
`endif
                A_PRESCALE: rdata_o[PRESC_W-1:0] = prescale_q;
                default:    rdata_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            enable_q    <= 1'b0;
            prescale_q  <= '0;
            presc_cnt_q <= '0;
            t_intr_q    <= 1'b0;
`ifdef TIMER_PERIODIC_EN
            periodic_q  <= 1'b0;
            period_q    <= '0;
`endif
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            enable_q    <= enable_d;
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
            t_intr_q    <= t_intr_d;
`ifdef TIMER_PERIODIC_EN
            periodic_q  <= periodic_d;
            period_q    <= period_d;
`endif
        end
    end

    assign t_intr = t_intr_q;

endmodule

// File: doc/timer_intr.md
TIMER_INTR -- requirements
Module: timer_intr

Interface
REQ-001 SHALL have parameter DW, default 32, bus data width; only 32 is supported.
REQ-002 SHALL have parameter PRESC_W, default 16, prescaler register width.
REQ-003 SHALL have port clk_i, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port cs, input, 1, chip select from peripheral bus.
REQ-006 SHALL have port we, input, 1, write enable; a write occurs when cs=1 and we=1.
REQ-007 SHALL have port mask, input, 4, byte-lane write enables; bit n gates wdata_i[8n+7:8n].
REQ-008 SHALL have port addr_i, input, 3, word index: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL, 5 PRESCALE, 6 PERIOD; 7 reserved.
REQ-009 SHALL have port wdata_i, input, DW, write data.
REQ-010 SHALL have port rdata_o, input-to-LSU output, DW, read data.
REQ-011 SHALL have port t_intr, output, 1, timer interrupt level to core.

Function
REQ-012 SHALL drive rdata_o combinationally from addr_i when cs=1, else 0; reserved index reads 0.
REQ-013 SHALL keep a 64-bit mtime, a 64-bit mtimecmp, CTRL[0]=enable, CTRL[1]=periodic, CTRL[31:2] reading 0.
REQ-014 SHALL keep a PRESC_W-bit prescale counter; with enable=1 it counts 0..PRESCALE and asserts a one-cycle tick on reaching PRESCALE, then wraps to 0.
REQ-015 SHALL increment mtime by 1 on each tick, carry from LO into HI; 0xFFFFFFFF_FFFFFFFF wraps to 0.
REQ-016 SHALL, with PRESCALE=0, tick every enabled cycle.
REQ-017 SHALL hold the prescale counter at 0 while enable=0 and on any write to PRESCALE or CTRL.
REQ-018 SHALL apply a software write to MTIME_LO or MTIME_HI in place of the increment in that cycle; the unwritten half holds, no carry.
REQ-019 SHALL register t_intr <= enable && (mtime >= mtimecmp), unsigned 64-bit compare on current register values; one-cycle latency.
REQ-020 SHALL deassert t_intr the cycle after software raises mtimecmp above mtime or clears enable.
REQ-021 SHALL merge byte-masked writes into the addressed register; mask=0 leaves it unchanged; reserved-index writes ignored.
REQ-022 SHALL give a software write to MTIMECMP priority over a periodic reload in the same cycle.

Reset
REQ-023 SHALL, when rst_i=0 at a clock edge, clear mtime, prescale counter, CTRL, PRESCALE, PERIOD and t_intr to 0 and set mtimecmp to 0xFFFFFFFF_FFFFFFFF.
REQ-024 SHALL let reset override any concurrent write or tick, including mid-count.
REQ-025 SHALL drive rdata_o=0 during reset regardless of cs.

Configuration
REQ-026 SHALL gate periodic reload with macro TIMER_PERIODIC_EN.
REQ-027 With TIMER_PERIODIC_EN defined: when enable=1, periodic=1 and mtime >= mtimecmp, SHALL update mtimecmp <= mtimecmp + {32'b0, PERIOD} (64-bit, wraps) next cycle; t_intr then pulses for one cycle per match.
REQ-028 Without TIMER_PERIODIC_EN: CTRL[1] and PERIOD SHALL read 0 and ignore writes; no reload logic exists.

Verification
REQ-029 Reset: rst_i=0 one cycle -> MTIME_LO/HI=0, MTIMECMP_HI=0xFFFFFFFF, CTRL=0, t_intr=0.
REQ-030 Compare: PRESCALE=0, MTIMECMP_LO=10, MTIMECMP_HI=0, CTRL=1 -> t_intr rises exactly one cycle after mtime reaches 10, stays high.
REQ-031 Prescale/carry: MTIME_LO=0xFFFFFFFE, PRESCALE=3, enable -> MTIME_HI becomes 1, MTIME_LO=0 after 8 cycles.
REQ-032 Byte mask: write 0xAABBCCDD to MTIMECMP_LO with mask=0b0101 over 0 -> reads 0x00BB00DD.
REQ-033 Collision: write MTIME_LO=0x100 on a tick cycle -> reads 0x100, not 0x101; write MTIMECMP=0x200 same cycle as reload -> 0x200.
REQ-034 Periodic (macro on): PRESCALE=0, MTIMECMP=20, PERIOD=20, CTRL=3 -> one-cycle t_intr pulses 20 cycles apart; macro off -> CTRL reads 1, t_intr stays high.
